fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage feeding the decode stage of the MIPS processor core. It owns the program counter and issues one request per cycle to a synchronous instruction memory with 1-cycle read latency. It accepts branch/jump redirects from execute. It presents {PC, instruction, valid} to decode, using a 2-entry skid buffer so that a decode stall never drops a returned word.

Parameters:
PC_WIDTH, 32, program counter width
IWIDTH, 32, instruction width
RESET_PC, 0, first fetch address after reset
PC_STEP, 4, sequential PC increment (byte addressing)

Ports:
f_clk  in  1  clock, rising edge
f_rst  in  1  reset: synchronous, active-high
f_i_ce  in  1  fetch enable; 0 = issue no new requests
f_i_change_pc  in  1  redirect request from execute
f_i_alu_pc  in  PC_WIDTH  redirect target
f_i_flush  in  1  kill in-flight and buffered instructions, no PC change
f_i_stall  in  1  decode not ready; hold f_o_* stable
f_o_imem_addr  out  PC_WIDTH  instruction memory address
f_o_imem_req  out  1  read strobe; data returns the next cycle
f_i_imem_data  in  IWIDTH  read data, valid 1 cycle after a req
f_o_pc  out  PC_WIDTH  PC of the presented instruction
f_o_instr  out  IWIDTH  presented instruction
f_o_ce  out  1  presented instruction valid

Behaviour:
- Reset (sampled on f_clk edge):
  - pc <- RESET_PC.
  - f_o_imem_req=0, f_o_ce=0, f_o_pc=0, f_o_instr=0.
  - Skid buffer emptied, in-flight flag cleared.
  - Reset mid-operation discards everything; a response arriving the cycle after reset is ignored.
- Issue: f_o_imem_req = f_i_ce & ~f_rst & (buffer occupancy + in-flight < 2). f_o_imem_addr = pc. On issue, pc <- pc + PC_STEP (mod 2^PC_WIDTH, wraps silently). The issued PC is recorded with an in-flight flag.
- Return: the cycle after an issue, f_i_imem_data paired with the recorded PC is pushed into the skid buffer, unless squashed.
- Output: the buffer head drives f_o_pc/f_o_instr with f_o_ce=1.
  - Head pops when f_o_ce & ~f_i_stall.
  - An empty buffer bypasses the return directly (latency req->f_o_ce = 1 cycle).
  - While f_i_stall=1, f_o_* must not change.
- Buffer: 2 entries.
  - Full (2) or 1 entry + 1 in flight blocks issue.
  - Simultaneous push and pop is allowed at any occupancy.
- Redirect (f_i_change_pc=1):
  - Buffer emptied.
  - In-flight response squashed (dropped next cycle).
  - f_o_ce=0 next cycle.
  - pc <- f_i_alu_pc.
  - The redirect cycle issues no request; the first request at the target is the following cycle. Target data reaches f_o_ce 2 cycles after the redirect edge.
  - Overrides f_i_stall.
- Flush: same as redirect except pc keeps its sequential value.
- Priority: f_rst > f_i_change_pc > f_i_flush > f_i_stall > issue.
- f_i_ce=0: no new issues. In-flight and buffered instructions still drain to decode.
- Misaligned redirect target: passed through unchanged (no alignment check).

Decomposition:
- Shared package (processor-wide): PC_WIDTH/IWIDTH defaults, RESET_PC, PC_STEP.
- One sub-module: fetch_skid_buf (2-entry FIFO holding {pc, instr}, push/pop/clear, full/empty/count). The top holds the PC register, in-flight/squash flags and issue logic.

Test Plan:
1. Reset held 2 cycles, then f_i_ce=1; memory returns word = addr: f_o_imem_addr 0,4,8,... on consecutive cycles; f_o_ce=1 from the 2nd cycle after release, f_o_pc/f_o_instr = 0/0, 4/4, 8/8 one per cycle.
2. Stall 3 cycles while streaming: f_o_pc frozen at its value; at most 2 instructions held; after release the sequence continues with no gap or duplicate (e.g. 8, 12, 16).
3. f_i_change_pc with f_i_alu_pc=0x100 while stalled and buffer full: next cycle f_o_ce=0; request at 0x100 one cycle later; f_o_pc=0x100 two cycles after the redirect; old PCs never appear.
4. f_i_flush in same cycle as a return: that word dropped; f_o_ce=0 next cycle; fetch resumes at the next sequential PC.
5. f_rst asserted mid-stream with an in-flight request: all outputs 0 next cycle; the stale response ignored; the first fetch after release is at RESET_PC.
6. pc preset to 0xFFFFFFFC via redirect: next sequential address 0x00000000 (wrap).

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Processor-wide fetch defaults shared by the fetch stage and its skid buffer.
// Widths, the reset vector and the sequential step are overridable per instance.
package fetch_stage_pkg;

    localparam int          PC_WIDTH_DEF = 32;
    localparam int          IWIDTH_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_STEP_DEF  = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of {pc, instr} pairs between instruction memory and decode.
// A push and a pop in the same cycle are both honoured at any occupancy.
module fetch_skid_buf
    import fetch_stage_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int IWIDTH   = IWIDTH_DEF
) (
    input  logic                f_clk,
    input  logic                f_rst,
    input  logic                clear,
    input  logic                push,
    input  logic [PC_WIDTH-1:0] push_pc,
    input  logic [IWIDTH-1:0]   push_instr,
    input  logic                pop,
    output logic [PC_WIDTH-1:0] head_pc,
    output logic [IWIDTH-1:0]   head_instr,
    output logic                full,
    output logic                empty,
    output logic [1:0]          count
);

    logic [PC_WIDTH-1:0] pc_mem    [2];
    logic [IWIDTH-1:0]   instr_mem [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          count_q;
    logic                do_push;
    logic                do_pop;
    logic                wipe;

    assign wipe  = f_rst | clear;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

    // When full, a push is only legal because the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    always_ff @(posedge f_clk) begin
        if (wipe) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge f_clk) begin
        if (do_push && !wipe) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one read per cycle to a 1-cycle memory
// and hands {pc, instr, valid} to decode through a 2-entry skid buffer.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  PC_WIDTH = PC_WIDTH_DEF,
    parameter int                  IWIDTH   = IWIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEF),
    parameter int                  PC_STEP  = PC_STEP_DEF
) (
    input  logic                f_clk,
    input  logic                f_rst,
    input  logic                f_i_ce,
    input  logic                f_i_change_pc,
    input  logic [PC_WIDTH-1:0] f_i_alu_pc,
    input  logic                f_i_flush,
    input  logic                f_i_stall,
    output logic [PC_WIDTH-1:0] f_o_imem_addr,
    output logic                f_o_imem_req,
    input  logic [IWIDTH-1:0]   f_i_imem_data,
    output logic [PC_WIDTH-1:0] f_o_pc,
    output logic [IWIDTH-1:0]   f_o_instr,
    output logic                f_o_ce
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] inflight_pc_q;
    logic                inflight_q;

    logic                kill;
    logic                ret_valid;
    logic                issue_room;
    logic                issue;
    logic                present_valid;
    logic                take;

    logic                buf_push;
    logic                buf_pop;
    logic [PC_WIDTH-1:0] head_pc;
    logic [IWIDTH-1:0]   head_instr;
    logic                buf_full;
    logic                buf_empty;
    logic [1:0]          buf_count;

    // Redirect and flush never issue, so nothing is in flight after them and the
    // only response to squash is the one returning during the kill cycle itself.
    assign kill      = f_i_change_pc | f_i_flush;
    assign ret_valid = inflight_q & ~f_rst & ~kill;

    // Never have more words owed to decode than the buffer can hold.
    assign issue_room = ~buf_full & ~((buf_count == 2'd1) & inflight_q);
    assign issue      = f_i_ce & ~f_rst & ~kill & issue_room;

    assign f_o_imem_req  = issue;
    assign f_o_imem_addr = pc_q;

    assign present_valid = ~f_rst & (~buf_empty | ret_valid);
    assign take          = present_valid & ~f_i_stall;

    always_comb begin
        f_o_ce    = present_valid;
        f_o_pc    = '0;
        f_o_instr = '0;
        if (present_valid) begin
            if (buf_empty) begin
                f_o_pc    = inflight_pc_q;
                f_o_instr = f_i_imem_data;
            end else begin
                f_o_pc    = head_pc;
                f_o_instr = head_instr;
            end
        end
    end

    // A bypassed return consumed by decode in the same cycle is never stored.
    assign buf_push = ret_valid & ~(buf_empty & take);
    assign buf_pop  = take & ~buf_empty;

    fetch_skid_buf #(
        .PC_WIDTH (PC_WIDTH),
        .IWIDTH   (IWIDTH)
    ) u_skid (
        .f_clk      (f_clk),
        .f_rst      (f_rst),
        .clear      (kill),
        .push       (buf_push),
        .push_pc    (inflight_pc_q),
        .push_instr (f_i_imem_data),
        .pop        (buf_pop),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .full       (buf_full),
        .empty      (buf_empty),
        .count      (buf_count)
    );

    always_ff @(posedge f_clk) begin
        if (f_rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (f_i_change_pc) begin
            pc_q       <= f_i_alu_pc;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + PC_WIDTH'(PC_STEP);
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based model of the fetch rules,
// with directed scenarios for stall, redirect, flush, mid-stream reset and PC wrap.
module tb_fetch_stage;

    logic        f_clk = 1'b0;
    logic        f_rst = 1'b1;
    logic        f_i_ce = 1'b0;
    logic        f_i_change_pc = 1'b0;
    logic [31:0] f_i_alu_pc = '0;
    logic        f_i_flush = 1'b0;
    logic        f_i_stall = 1'b0;
    logic [31:0] f_o_imem_addr;
    logic        f_o_imem_req;
    logic [31:0] f_i_imem_data = '0;
    logic [31:0] f_o_pc;
    logic [31:0] f_o_instr;
    logic        f_o_ce;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: sequential PC, PCs owed to decode, outstanding request.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_q[$];
    logic        m_inf = 1'b0;
    logic [31:0] m_inf_pc = 32'h0;

    fetch_stage dut (
        .f_clk         (f_clk),
        .f_rst         (f_rst),
        .f_i_ce        (f_i_ce),
        .f_i_change_pc (f_i_change_pc),
        .f_i_alu_pc    (f_i_alu_pc),
        .f_i_flush     (f_i_flush),
        .f_i_stall     (f_i_stall),
        .f_o_imem_addr (f_o_imem_addr),
        .f_o_imem_req  (f_o_imem_req),
        .f_i_imem_data (f_i_imem_data),
        .f_o_pc        (f_o_pc),
        .f_o_instr     (f_o_instr),
        .f_o_ce        (f_o_ce)
    );

    always #5 f_clk = ~f_clk;

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0000;
    endfunction

    // Memory returns garbage on cycles with no request, so unqualified use shows up.
    always @(posedge f_clk) begin
        f_i_imem_data <= f_o_imem_req ? word_of(f_o_imem_addr) : $urandom();
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ce, input logic chg,
                         input logic [31:0] alu, input logic flush, input logic stall);
        f_rst         = rst;
        f_i_ce        = ce;
        f_i_change_pc = chg;
        f_i_alu_pc    = alu;
        f_i_flush     = flush;
        f_i_stall     = stall;
        #1;
    endtask

    // Compare this cycle against the model, advance the model, move to next cycle.
    task automatic model_cycle();
        int          occ;
        logic        ret;
        logic        e_ce;
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        occ     = m_q.size() + (m_inf ? 1 : 0);
        ret     = m_inf & ~f_rst & ~f_i_change_pc & ~f_i_flush;
        e_ce    = ~f_rst & ((m_q.size() != 0) | ret);
        e_pc    = !e_ce ? 32'h0 : ((m_q.size() != 0) ? m_q[0] : m_inf_pc);
        e_instr = e_ce ? word_of(e_pc) : 32'h0;
        e_req   = f_i_ce & ~f_rst & ~f_i_change_pc & ~f_i_flush & (occ < 2);

        chk_eq("imem_req", {31'h0, f_o_imem_req}, {31'h0, e_req});
        chk_eq("o_ce", {31'h0, f_o_ce}, {31'h0, e_ce});
        chk_eq("o_pc", f_o_pc, e_pc);
        chk_eq("o_instr", f_o_instr, e_instr);
        if (e_req) chk_eq("imem_addr", f_o_imem_addr, m_pc);

        if (f_rst) begin
            m_pc  = 32'h0;
            m_q.delete();
            m_inf = 1'b0;
        end else if (f_i_change_pc) begin
            m_pc  = f_i_alu_pc;
            m_q.delete();
            m_inf = 1'b0;
        end else if (f_i_flush) begin
            m_q.delete();
            m_inf = 1'b0;
        end else begin
            if (ret) m_q.push_back(m_inf_pc);
            if (e_ce && !f_i_stall) void'(m_q.pop_front());
            m_inf = e_req;
            if (e_req) begin
                m_inf_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
        end
        if (m_q.size() > 2) chk_eq("model_occupancy", m_q.size(), 2);
        @(negedge f_clk);
    endtask

    task automatic cyc(input logic rst, input logic ce, input logic chg,
                       input logic [31:0] alu, input logic flush, input logic stall);
        drive(rst, ce, chg, alu, flush, stall);
        model_cycle();
    endtask

    initial begin
        @(negedge f_clk);

        // Reset for two cycles, then stream from RESET_PC.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t1_first_addr", f_o_imem_addr, 32'h0);
        chk_eq("t1_first_req", {31'h0, f_o_imem_req}, 32'h1);
        chk_eq("t1_no_ce_yet", {31'h0, f_o_ce}, 32'h0);
        model_cycle();
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t1_pc0", f_o_pc, 32'h0);
        chk_eq("t1_instr0", f_o_instr, word_of(32'h0));
        model_cycle();
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t1_pc4", f_o_pc, 32'h4);
        model_cycle();
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t1_pc8", f_o_pc, 32'h8);
        model_cycle();

        // Stall three cycles: output frozen at 12, then 12, 16, 20 with no gap.
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 1);
        chk_eq("t2_frozen_pc", f_o_pc, 32'hC);
        model_cycle();
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t2_resume_pc12", f_o_pc, 32'hC);
        model_cycle();
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t2_resume_pc16", f_o_pc, 32'h10);
        model_cycle();
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t2_resume_pc20", f_o_pc, 32'h14);
        model_cycle();

        // Fill the buffer under stall, then redirect to 0x100 while still stalled.
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 1, 1, 32'h100, 0, 1);
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t3_ce_dropped", {31'h0, f_o_ce}, 32'h0);
        chk_eq("t3_target_addr", f_o_imem_addr, 32'h100);
        chk_eq("t3_target_req", {31'h0, f_o_imem_req}, 32'h1);
        model_cycle();
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t3_target_pc", f_o_pc, 32'h100);
        chk_eq("t3_target_ce", {31'h0, f_o_ce}, 32'h1);
        model_cycle();
        cyc(0, 1, 0, 0, 0, 0);

        // Flush in a cycle with a return outstanding.
        cyc(0, 1, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t4_ce_after_flush", {31'h0, f_o_ce}, 32'h0);
        model_cycle();
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);

        // Reset mid-stream with a request in flight.
        cyc(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        chk_eq("t5_rst_ce", {31'h0, f_o_ce}, 32'h0);
        chk_eq("t5_rst_pc", f_o_pc, 32'h0);
        chk_eq("t5_rst_instr", f_o_instr, 32'h0);
        chk_eq("t5_rst_req", {31'h0, f_o_imem_req}, 32'h0);
        model_cycle();
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t5_restart_addr", f_o_imem_addr, 32'h0);
        model_cycle();
        cyc(0, 1, 0, 0, 0, 0);

        // PC wrap through the top of the address space.
        cyc(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t6_top_addr", f_o_imem_addr, 32'hFFFF_FFFC);
        model_cycle();
        drive(0, 1, 0, 0, 0, 0);
        chk_eq("t6_wrap_addr", f_o_imem_addr, 32'h0);
        model_cycle();
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);

        // Random traffic, including misaligned redirect targets.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] alu;
            case ($urandom_range(0, 3))
                0:       alu = $urandom();
                1:       alu = 32'hFFFF_FFF0 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
                default: alu = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            endcase
            cyc($urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 90,
                $urandom_range(0, 99) < 5,
                alu,
                $urandom_range(0, 99) < 5,
                $urandom_range(0, 99) < 35);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
